// File: rtl/wb_sample_fifo_pkg.sv
// Shared constants for the Wishbone sample FIFO: register offsets, STATUS/CTRL bit
// positions and the bus FSM state encodings.
package wb_sample_fifo_pkg;

  // Register offsets, decoded from adr[3:2]
  localparam logic [1:0] RegData   = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;
  localparam logic [1:0] RegCtrl   = 2'd2;
  localparam logic [1:0] RegThresh = 2'd3;

  // STATUS bit positions (count occupies the low bits)
  localparam int unsigned StatEmptyBit = 16;
  localparam int unsigned StatFullBit  = 17;
  localparam int unsigned StatOvfBit   = 18;
  localparam int unsigned StatUnfBit   = 19;
  localparam int unsigned StatIrqBit   = 20;

  // CTRL bit positions
  localparam int unsigned CtrlFlushBit = 0;
  localparam int unsigned CtrlIrqEnBit = 1;

  // Bus FSM states
  localparam logic StIdle = 1'b0;
  localparam logic StResp = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with dual pointers, occupancy count and a flush that overrides
// any same-cycle push/pop. Head entry is read combinationally.
module sync_fifo #(
  parameter int unsigned dw    = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [dw-1:0]            wdata,
  output logic [dw-1:0]            rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [dw-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  always_comb begin
    full    = (count_q == (AW+1)'(DEPTH));
    empty   = (count_q == '0);
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    rdata   = mem[rd_ptr_q];
    count   = count_q;
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/wb_sample_fifo.sv
// Wishbone B3 slave exposing a sample FIFO (DATA push/pop), STATUS, CTRL and a
// level-threshold interrupt. Every request is answered after one cycle with ack or err.
module wb_sample_fifo
  import wb_sample_fifo_pkg::*;
#(
  parameter int unsigned dw    = 32,
  parameter int unsigned aw    = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic [aw-1:0] wb_s_adr_i,
  input  logic [dw-1:0] wb_s_dat_i,
  input  logic [3:0]    wb_s_sel_i,
  input  logic          wb_s_we_i,
  input  logic          wb_s_cyc_i,
  input  logic          wb_s_stb_i,
  input  logic [2:0]    wb_s_cti_i,
  input  logic [1:0]    wb_s_bte_i,
  output logic [dw-1:0] wb_s_dat_o,
  output logic          wb_s_ack_o,
  output logic          wb_s_err_o,
  output logic          wb_s_rty_o,
  output logic          irq
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          state_q;
  logic          ack_q, err_q, irq_q;
  logic [dw-1:0] dat_q;
  logic          irq_en_q, ovf_q, unf_q;
  logic [15:0]   thresh_q;

  logic          req, bus_err;
  logic [1:0]    reg_sel;
  logic          push, pop, flush;
  logic [dw-1:0] head, rd_data, status;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          unused_ok;

  // Bursts are treated as classic cycles, so cti/bte and the upper address are ignored
  assign unused_ok = ^{wb_s_adr_i[aw-1:4], wb_s_adr_i[1:0], wb_s_cti_i, wb_s_bte_i,
                       wb_s_sel_i[3:2]};

  always_comb begin
    req     = (state_q == StIdle) & wb_s_cyc_i & wb_s_stb_i;
    reg_sel = wb_s_adr_i[3:2];
    bus_err = (reg_sel == RegData) & (wb_s_we_i ? full : empty);
    push    = req & wb_s_we_i & (reg_sel == RegData) & ~full;
    pop     = req & ~wb_s_we_i & (reg_sel == RegData) & ~empty;
    flush   = req & wb_s_we_i & (reg_sel == RegCtrl) & wb_s_sel_i[0] &
              wb_s_dat_i[CtrlFlushBit];

    status                = '0;
    status[CW-1:0]        = count;
    status[StatEmptyBit]  = empty;
    status[StatFullBit]   = full;
    status[StatOvfBit]    = ovf_q;
    status[StatUnfBit]    = unf_q;
    status[StatIrqBit]    = irq_q;

    rd_data = '0;
    unique case (reg_sel)
      RegData:   rd_data = empty ? '0 : head;
      RegStatus: rd_data = status;
      RegCtrl:   rd_data[CtrlIrqEnBit] = irq_en_q;
      RegThresh: rd_data[15:0] = thresh_q;
    endcase
  end

  sync_fifo #(
    .dw    (dw),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (wb_clk),
    .rst   (wb_rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wb_s_dat_i),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q  <= StIdle;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dat_q    <= '0;
      irq_q    <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      thresh_q <= '0;
    end else begin
      // count is already post-update here, so irq follows it by one cycle
      irq_q <= irq_en_q & (thresh_q != '0) & (16'(count) >= thresh_q);
      case (state_q)
        StIdle: begin
          if (req) begin
            state_q <= StResp;
            ack_q   <= ~bus_err;
            err_q   <= bus_err;
            dat_q   <= wb_s_we_i ? '0 : rd_data;
            if (wb_s_we_i) begin
              unique case (reg_sel)
                RegData: if (full) ovf_q <= 1'b1;
                RegStatus: begin
                  if (wb_s_dat_i[StatOvfBit]) ovf_q <= 1'b0;
                  if (wb_s_dat_i[StatUnfBit]) unf_q <= 1'b0;
                end
                RegCtrl: begin
                  if (wb_s_sel_i[0]) begin
                    irq_en_q <= wb_s_dat_i[CtrlIrqEnBit];
                    if (wb_s_dat_i[CtrlFlushBit]) begin
                      ovf_q <= 1'b0;
                      unf_q <= 1'b0;
                    end
                  end
                end
                RegThresh: begin
                  if (wb_s_sel_i[0]) thresh_q[7:0]  <= wb_s_dat_i[7:0];
                  if (wb_s_sel_i[1]) thresh_q[15:8] <= wb_s_dat_i[15:8];
                end
              endcase
            end else if (reg_sel == RegData && empty) begin
              unf_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign wb_s_dat_o = dat_q;
  assign wb_s_ack_o = ack_q;
  assign wb_s_err_o = err_q;
  assign wb_s_rty_o = 1'b0;
  assign irq        = irq_q;

endmodule
